// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the bit-serial ALU controller.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice: ADD/SUB share the XOR sum; carry and borrow are both produced
// so the controller can pick whichever one the opcode chains.
module alu_bit_slice (
    input  logic A,
    input  logic B,
    input  logic CarryIn,
    input  logic S1,
    input  logic S2,
    output logic ResAlu,
    output logic CarrySum,
    output logic Borrow
);

    always_comb begin
        ResAlu = A ^ B ^ CarryIn;
        if (S2) begin
            ResAlu = S1 ? (A | B) : (A & B);
        end
    end

    assign CarrySum = (A & B) | (A & CarryIn) | (B & CarryIn);
    // Borrow of A - B - CarryIn: majority with A inverted.
    assign Borrow   = (~A & B) | (~A & CarryIn) | (B & CarryIn);

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial N-bit ALU controller: latches operands on Start, runs one slice
// evaluation per clock LSB first, then pulses Done for one cycle with the result.
//
// Handshake: Start is sampled only while Ready=1 (IDLE); once accepted, inputs may
// change freely and further Start pulses are ignored until Ready returns. Done is a
// one-cycle pulse, and Result/CarryOut/Zero are valid from that cycle until the next
// operation completes.
module alu_serial_seq
    import alu_pkg::*;
#(
    parameter int Width = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [Width-1:0] OpA,
    input  logic [Width-1:0] OpB,
    output logic             Ready,
    output logic             Busy,
    output logic             Done,
    output logic [Width-1:0] Result,
    output logic             CarryOut,
    output logic             Zero,
    output state_t           DbgState
);

    localparam int CntW = $clog2(Width + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(Width - 1);

    state_t           state_q;
    logic [CntW-1:0]  cnt_q;
    logic [Width-1:0] sh_a_q;
    logic [Width-1:0] sh_b_q;
    logic [Width-1:0] sh_r_q;
    logic [1:0]       op_q;
    logic             chain_q;
    logic [Width-1:0] result_q;
    logic             carry_q;
    logic             zero_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;

    logic             slice_res_d;
    logic             slice_carry_d;
    logic             slice_borrow_d;
    logic             chain_d;
    logic [Width-1:0] res_shift_d;

    alu_bit_slice u_slice (
        .A        (sh_a_q[0]),
        .B        (sh_b_q[0]),
        .CarryIn  (chain_q),
        .S1       (op_q[0]),
        .S2       (op_q[1]),
        .ResAlu   (slice_res_d),
        .CarrySum (slice_carry_d),
        .Borrow   (slice_borrow_d)
    );

    // Logic ops never chain, so the flop (and thus CarryOut) stays 0 for them.
    always_comb begin
        chain_d = 1'b0;
        case (op_q)
            OP_ADD:  chain_d = slice_carry_d;
            OP_SUB:  chain_d = slice_borrow_d;
            default: chain_d = 1'b0;
        endcase
        res_shift_d = {slice_res_d, sh_r_q[Width-1:1]};
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sh_a_q   <= '0;
            sh_b_q   <= '0;
            sh_r_q   <= '0;
            op_q     <= OP_ADD;
            chain_q  <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (Start) begin
                        sh_a_q  <= OpA;
                        sh_b_q  <= OpB;
                        sh_r_q  <= '0;
                        op_q    <= Op;
                        chain_q <= 1'b0;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sh_a_q  <= sh_a_q >> 1;
                    sh_b_q  <= sh_b_q >> 1;
                    sh_r_q  <= res_shift_d;
                    chain_q <= chain_d;
                    cnt_q   <= cnt_q + CntW'(1);
                    // Visible flags change only here, so they stay stable during the next run.
                    if (cnt_q == LastCnt) begin
                        result_q <= res_shift_d;
                        carry_q  <= chain_d;
                        zero_q   <= (res_shift_d == '0);
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign Ready    = ready_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Result   = result_q;
    assign CarryOut = carry_q;
    assign Zero     = zero_q;
    assign DbgState = state_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Self-checking bench for alu_serial_seq (Width=4): directed cases plus random
// operations compared against an arithmetic reference model.
module tb_alu_serial_seq;
  import alu_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         zero;
  state_t       dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] prev_res;

  alu_serial_seq #(.Width(W)) dut (
    .Clk      (clk),
    .Reset    (reset),
    .Start    (start),
    .Op       (op),
    .OpA      (op_a),
    .OpB      (op_b),
    .Ready    (ready),
    .Busy     (busy),
    .Done     (done),
    .Result   (result),
    .CarryOut (carry_out),
    .Zero     (zero),
    .DbgState (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", tag, got, exp);
  endtask

  // reference model: plain modular arithmetic on integers
  function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic c);
    int ai = int'(a);
    int bi = int'(b);
    int m  = 1 << W;
    case (o)
      2'b00: begin r = W'((ai + bi) % m);     c = (ai + bi) >= m; end
      2'b01: begin r = W'((ai - bi + m) % m); c = ai < bi;        end
      2'b10: begin r = a & b;                 c = 1'b0;           end
      default: begin r = a | b;               c = 1'b0;           end
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready;
    int n = 0;
    while (!ready && n < 40) begin
      tick();
      n++;
    end
    if (!ready) check("ready_timeout", 32'(ready), 1);
  endtask

  // driver: issue one operation, optionally poke Start/operands during the run
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit poke);
    logic [W-1:0] exp_r;
    logic         exp_c;
    int           done_cnt = 0;
    int           first = -1;
    model(o, a, b, exp_r, exp_c);
    wait_ready();
    start = 1'b1; op = o; op_a = a; op_b = b;
    tick();
    start = 1'b0;
    op_a = W'($urandom); op_b = W'($urandom); op = 2'($urandom);
    for (int e = 1; e <= W + 2; e++) begin
      if (poke && e <= W - 2) begin
        start = 1'b1;
        op_a = W'($urandom); op_b = W'($urandom); op = 2'($urandom);
      end else begin
        start = 1'b0;
      end
      tick();
      if (e <= W) begin
        check("busy_run", 32'(busy), 1);
        check("ready_run", 32'(ready), 0);
      end
      if (e < W) check("result_hold_run", 32'(result), 32'(prev_res));
      if (e == W + 1) begin
        check("busy_after", 32'(busy), 0);
        check("ready_after", 32'(ready), 1);
      end
      if (done) begin
        done_cnt++;
        if (first < 0) first = e;
      end
    end
    check("done_pulses", 32'(done_cnt), 1);
    check("latency", 32'(first), W);
    check("result", 32'(result), 32'(exp_r));
    check("carry_out", 32'(carry_out), 32'(exp_c));
    check("zero", 32'(zero), 32'(exp_r == '0));
    prev_res = exp_r;
  endtask

  typedef struct {
    logic [1:0]   o;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } vec_t;

  initial begin
    vec_t dir[5];
    int   dones;
    dir[0] = '{2'b00, 4'hF, 4'h1};
    dir[1] = '{2'b01, 4'h3, 4'h5};
    dir[2] = '{2'b01, 4'h9, 4'h9};
    dir[3] = '{2'b10, 4'hC, 4'hA};
    dir[4] = '{2'b11, 4'hC, 4'hA};

    reset = 1'b1; start = 1'b1; op = 2'b00; op_a = 4'h5; op_b = 4'h6;
    tick();
    tick();
    check("rst_ready", 32'(ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_result", 32'(result), 0);
    check("rst_zero", 32'(zero), 1);
    check("rst_carry", 32'(carry_out), 0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b0; start = 1'b0;
    tick();
    check("post_rst_ready", 32'(ready), 1);
    check("post_rst_busy", 32'(busy), 0);
    prev_res = '0;

    // directed cases
    foreach (dir[i]) run_op(dir[i].o, dir[i].a, dir[i].b, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_hold", 32'(result), 32'hE);
      check("idle_ready", 32'(ready), 1);
    end

    // Start pulses and operand churn during a run must be ignored
    run_op(2'b00, 4'h5, 4'h6, 1'b1);

    // reset during the second RUN cycle aborts the operation
    wait_ready();
    start = 1'b1; op = 2'b00; op_a = 4'h7; op_b = 4'h7;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_ready", 32'(ready), 1);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_result", 32'(result), 0);
    check("abort_zero", 32'(zero), 1);
    dones = 0;
    for (int i = 0; i < W + 3; i++) begin
      tick();
      if (done) dones++;
    end
    check("abort_no_done", 32'(dones), 0);
    prev_res = '0;
    run_op(2'b00, 4'h2, 4'h3, 1'b0);

    // random operations
    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom_range(0, 3)), W'($urandom), W'($urandom), bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
